// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for the five-entry control register bank.
// One committed write per three cycles; valid/ack handshake per requester.
module reg_write_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 7,
   parameter int DATA_W  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ack,
   output logic                      addr_err,
   output logic                      busy,
   output logic [DATA_W-1:0]         en_reg_out_7_0,
   output logic [DATA_W-1:0]         en_reg_out_15_8,
   output logic [DATA_W-1:0]         en_reg_pwm_7_0,
   output logic [DATA_W-1:0]         en_reg_pwm_15_8,
   output logic [DATA_W-1:0]         pwm_duty_cycle
);

   localparam int IDX_W = $clog2(NUM_REQ);

   localparam logic [ADDR_W-1:0] A_OUT_LO = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] A_OUT_HI = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_PWM_LO = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] A_PWM_HI = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] A_DUTY   = ADDR_W'(4);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      ACK
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [IDX_W-1:0]  last;
   logic [IDX_W-1:0]  win;
   logic              found;
   logic [IDX_W-1:0]  cap_idx;
   logic [ADDR_W-1:0] cap_addr;
   logic [DATA_W-1:0] cap_data;

   // Requester index reached by stepping k places past base, wrapping.
   function automatic logic [IDX_W-1:0] rr_idx(
      input logic [IDX_W-1:0] base,
      input int               k
   );
      int s;
      s = int'(base) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return IDX_W'(s);
   endfunction

   // Pick the first valid requester after the last one served.
   always_comb begin
      found = 1'b0;
      win   = last;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!found && req_valid[rr_idx(last, k)]) begin
            found = 1'b1;
            win   = rr_idx(last, k);
         end
      end
   end

   // Next-state logic: a pass is always IDLE -> WRITE -> ACK -> IDLE.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (found) state_nxt = WRITE;
         WRITE:   state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Capture the winner, commit the write, and pulse ack/err for one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last            <= IDX_W'(NUM_REQ - 1);
         cap_idx         <= '0;
         cap_addr        <= '0;
         cap_data        <= '0;
         req_ack         <= '0;
         addr_err        <= 1'b0;
         en_reg_out_7_0  <= '0;
         en_reg_out_15_8 <= '0;
         en_reg_pwm_7_0  <= '0;
         en_reg_pwm_15_8 <= '0;
         pwm_duty_cycle  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (found) begin
                  cap_idx  <= win;
                  cap_addr <= req_addr[win*ADDR_W +: ADDR_W];
                  cap_data <= req_data[win*DATA_W +: DATA_W];
               end
            end
            WRITE: begin
               unique case (cap_addr)
                  A_OUT_LO: en_reg_out_7_0  <= cap_data;
                  A_OUT_HI: en_reg_out_15_8 <= cap_data;
                  A_PWM_LO: en_reg_pwm_7_0  <= cap_data;
                  A_PWM_HI: en_reg_pwm_15_8 <= cap_data;
                  A_DUTY:   pwm_duty_cycle  <= cap_data;
                  default:  addr_err        <= 1'b1;
               endcase
               req_ack <= NUM_REQ'(1) << cap_idx;
               last    <= cap_idx;
            end
            ACK: begin
               req_ack  <= '0;
               addr_err <= 1'b0;
            end
            default: begin
               req_ack  <= '0;
               addr_err <= 1'b0;
            end
         endcase
      end
   end

endmodule
